operand_stage: RTL and testbench

Decode/operand-fetch stage that directly feeds the `arithmetic` unit. It accepts one RV32I OP or OP-IMM instruction at a time and reads rs1/rs2 from an internal 32×32 register file. It drives lhs/rhs/operation/metadata with their valid flags, then writes the returned result back to rd. It also counts retired instructions and flags illegal ones.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/register_file.sv | 44 ++++
 rtl/operand_stage.sv | 142 ++++++++++++++
 tb/tb_operand_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, funct3 and stage-state definitions
package cpu_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] FUNCT7_ALT    = 7'h20;

  typedef enum logic [2:0] {
    F3_ADD  = 3'd0,
    F3_SLL  = 3'd1,
    F3_SLT  = 3'd2,
    F3_SLTU = 3'd3,
    F3_XOR  = 3'd4,
    F3_SR   = 3'd5,
    F3_OR   = 3'd6,
    F3_AND  = 3'd7
  } funct3_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } stage_state_e;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SR);
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 2 sampled read ports, 1 write port, combinational debug port
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read data is captured at the accept edge and held for the whole EXEC phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_data <= '0;
      rs2_data <= '0;
    end else if (rd_en) begin
      rs1_data <= (rs1_addr == '0) ? '0 : regs[rs1_addr];
      rs2_data <= (rs2_addr == '0) ? '0 : regs[rs2_addr];
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - OP/OP-IMM decode and operand fetch feeding the arithmetic unit
module operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [XLEN-1:0] lhs,
  output logic            lhs_valid,
  output logic [XLEN-1:0] rhs,
  output logic            rhs_valid,
  output logic [2:0]      operation,
  output logic            operation_valid,
  output logic [6:0]      metadata,
  output logic            metadata_valid,
  input  logic [XLEN-1:0] result,
  input  logic            arithmetic_code_valid,
  input  logic            result_valid,
  output logic            illegal,
  output logic [31:0]     retired,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  stage_state_e    state_q, state_d;
  logic            load, commit, illegal_d;
  logic            is_op, is_op_imm, legal;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_d, imm_q;
  logic [6:0]      metadata_d, metadata_q;
  logic [2:0]      operation_q;
  logic [AW-1:0]   rd_q;
  logic            use_rs2_q;
  logic            illegal_q;
  logic [31:0]     retired_q;
  logic [XLEN-1:0] rs1_data, rs2_data;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign is_op     = (opcode == OPCODE_OP);
  assign is_op_imm = (opcode == OPCODE_OP_IMM);
  assign legal     = is_op || is_op_imm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    load        = 1'b0;
    commit      = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          load      = legal;
          illegal_d = !legal;
          if (legal) state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!arithmetic_code_valid) begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (result_valid) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Non-shift immediates zero funct7 so ADDI with imm[11:5]=0x20 is not seen as SUB.
  always_comb begin
    imm_d      = {{(XLEN-12){instr[31]}}, instr[31:20]};
    metadata_d = instr[31:25];
    if (is_op_imm) begin
      if (is_shift(funct3)) imm_d = {{(XLEN-5){1'b0}}, instr[24:20]};
      else                  metadata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imm_q       <= '0;
      metadata_q  <= '0;
      operation_q <= '0;
      rd_q        <= '0;
      use_rs2_q   <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      illegal_q <= illegal_d;
      if (commit) retired_q <= retired_q + 32'd1;
      if (load) begin
        imm_q       <= imm_d;
        metadata_q  <= metadata_d;
        operation_q <= funct3;
        rd_q        <= AW'(instr[11:7]);
        use_rs2_q   <= is_op;
      end
    end
  end

  register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_register_file (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (load),
    .rs1_addr (AW'(instr[19:15])),
    .rs2_addr (AW'(instr[24:20])),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (commit),
    .wr_addr  (rd_q),
    .wr_data  (result),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign lhs             = rs1_data;
  assign rhs             = use_rs2_q ? rs2_data : imm_q;
  assign operation       = operation_q;
  assign metadata        = metadata_q;
  assign lhs_valid       = (state_q == ST_EXEC);
  assign rhs_valid       = (state_q == ST_EXEC);
  assign operation_valid = (state_q == ST_EXEC);
  assign metadata_valid  = (state_q == ST_EXEC);
  assign illegal         = illegal_q;
  assign retired         = retired_q;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - directed plus random check of operand_stage against a reference model
module tb_operand_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] lhs, rhs;
  logic        lhs_valid, rhs_valid, operation_valid, metadata_valid;
  logic [2:0]  operation;
  logic [6:0]  metadata;
  logic [31:0] result = '0;
  logic        arithmetic_code_valid = 1'b0;
  logic        result_valid = 1'b0;
  logic        illegal;
  logic [31:0] retired;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .instr                 (instr),
    .instr_valid           (instr_valid),
    .instr_ready           (instr_ready),
    .lhs                   (lhs),
    .lhs_valid             (lhs_valid),
    .rhs                   (rhs),
    .rhs_valid             (rhs_valid),
    .operation             (operation),
    .operation_valid       (operation_valid),
    .metadata              (metadata),
    .metadata_valid        (metadata_valid),
    .result                (result),
    .arithmetic_code_valid (arithmetic_code_valid),
    .result_valid          (result_valid),
    .illegal               (illegal),
    .retired               (retired),
    .dbg_addr              (dbg_addr),
    .dbg_data              (dbg_data)
  );

  logic [31:0] model_r [32];
  logic [31:0] model_ret;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] valids();
    return {lhs_valid, rhs_valid, operation_valid, metadata_valid};
  endfunction

  // Behaviour of a well-formed RV32I arithmetic unit, used to play the downstream block.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input bit is_op);
    case (f3)
      3'd0: return (is_op && f7 == FUNCT7_ALT) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return (f7 == FUNCT7_ALT) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit code_ok(input logic [2:0] f3, input logic [6:0] f7, input bit is_op);
    case (f3)
      3'd0:    return is_op ? (f7 == 7'h00 || f7 == FUNCT7_ALT) : 1'b1;
      3'd1:    return f7 == 7'h00;
      3'd5:    return f7 == 7'h00 || f7 == FUNCT7_ALT;
      default: return is_op ? (f7 == 7'h00) : 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_r[i] = '0;
    model_ret = '0;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Entered shortly after a rising edge with the stage idle.
  task automatic run_instr(input logic [31:0] ins, input int stall);
    logic [6:0]  op7, f7, e_meta;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] e_lhs, e_rhs, res;
    bit          is_op, legal, ok;
    op7 = ins[6:0]; f3 = ins[14:12]; rd = ins[11:7];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    is_op = (op7 == OPCODE_OP);
    legal = is_op || (op7 == OPCODE_OP_IMM);
    e_lhs = model_r[rs1];
    if (is_op) begin
      e_rhs = model_r[rs2]; e_meta = f7;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      e_rhs = {27'd0, rs2}; e_meta = f7;
    end else begin
      e_rhs = {{20{ins[31]}}, ins[31:20]}; e_meta = 7'h00;
    end
    ok  = code_ok(f3, f7, is_op);
    res = alu_ref(e_lhs, e_rhs, f3, e_meta, is_op);

    instr = ins; instr_valid = 1'b1;
    check("ready_idle", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom;
    if (!legal) begin
      check("illegal_pulse", 32'(illegal), 32'd1);
      check("illegal_no_valids", 32'(valids()), 32'd0);
      check("illegal_ready", 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      check("illegal_width", 32'(illegal), 32'd0);
      check("illegal_retired", retired, model_ret);
      return;
    end
    check("exec_valids", 32'(valids()), 32'hf);
    check("exec_ready", 32'(instr_ready), 32'd0);
    check("lhs", lhs, e_lhs);
    check("rhs", rhs, e_rhs);
    check("operation", 32'(operation), 32'(f3));
    check("metadata", 32'(metadata), 32'(e_meta));
    arithmetic_code_valid = 1'b1; result_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valids", 32'(valids()), 32'hf);
      check("stall_lhs", lhs, e_lhs);
      check("stall_rhs", rhs, e_rhs);
    end
    arithmetic_code_valid = ok; result_valid = 1'b1; result = res;
    @(posedge clk); #1;
    arithmetic_code_valid = 1'b0; result_valid = 1'b0; result = $urandom;
    if (ok) begin
      if (rd != 5'd0) model_r[rd] = res;
      model_ret = model_ret + 32'd1;
    end
    check("done_illegal", 32'(illegal), ok ? 32'd0 : 32'd1);
    check("done_ready", 32'(instr_ready), 32'd1);
    check("done_valids", 32'(valids()), 32'd0);
    check("retired", retired, model_ret);
    check_reg("rd_value", rd, model_r[rd]);
  endtask

  task automatic random_instr(output logic [31:0] ins);
    int r;
    logic [6:0] f7;
    ins = $urandom;
    r = $urandom_range(0, 9);
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = FUNCT7_ALT;
      default: f7 = 7'($urandom);
    endcase
    if (r < 4) begin
      ins[6:0] = OPCODE_OP; ins[31:25] = f7;
    end else if (r < 8) begin
      ins[6:0] = OPCODE_OP_IMM;
      if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ins[31:25] = f7;
    end else if (ins[6:0] == OPCODE_OP || ins[6:0] == OPCODE_OP_IMM) begin
      ins[6:0] = 7'h7f;
    end
  endtask

  initial begin
    logic [31:0] ins;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_retired", retired, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_valids", 32'(valids()), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    check("post_rst_valids", 32'(valids()), 32'd0);
    check_reg("post_rst_x5", 5'd5, 32'd0);
    check("post_rst_retired", retired, 32'd0);

    run_instr(32'h00500093, 0);
    check_reg("addi_x1", 5'd1, 32'd5);
    check("addi_retired", retired, 32'd1);
    run_instr(32'hfff00113, 1);
    check_reg("addi_x2", 5'd2, 32'hffff_ffff);
    run_instr(32'h402081b3, 0);
    check_reg("sub_x3", 5'd3, 32'd6);
    run_instr(32'h40415213, 2);
    check_reg("srai_x4", 5'd4, 32'hffff_ffff);
    run_instr(32'h00708013, 0);
    check_reg("x0_zero", 5'd0, 32'd0);
    check("x0_retired", retired, 32'd5);
    run_instr(32'h00000000, 0);
    run_instr(32'h022081b3, 0);
    check_reg("bad_f7_x3", 5'd3, 32'd6);
    check("bad_f7_retired", retired, 32'd5);

    // Reset arriving asynchronously while an instruction is in EXEC.
    instr = 32'h402081b3; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("mid_exec_valids", 32'(valids()), 32'hf);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valids", 32'(valids()), 32'd0);
    check("mid_rst_lhs", lhs, 32'd0);
    check("mid_rst_rhs", rhs, 32'd0);
    check("mid_rst_operation", 32'(operation), 32'd0);
    check("mid_rst_metadata", 32'(metadata), 32'd0);
    check("mid_rst_retired", retired, 32'd0);
    check("mid_rst_illegal", 32'(illegal), 32'd0);
    check_reg("mid_rst_x1", 5'd1, 32'd0);
    check_reg("mid_rst_x3", 5'd3, 32'd0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", 32'(instr_ready), 32'd1);
    check("mid_rst_no_illegal", 32'(illegal), 32'd0);

    for (int n = 0; n < 300; n++) begin
      random_instr(ins);
      run_instr(ins, $urandom_range(0, 2));
    end
    for (int i = 0; i < 32; i++) check_reg("final_reg", 5'(i), model_r[i]);
    check("final_retired", retired, model_ret);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
